// File: rtl/dsp48a1_result_monitor.sv
// Response-side checker for a DSP48A1 slice: golden model, LATENCY-deep expectation pipe, counters.
// Optional build macro DSP_MON_HALT_ON_ERR_EN adds a FAIL state entered on the first mismatch.
module dsp48a1_result_monitor #(
    parameter int LATENCY = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             vld_in,
    input  logic [17:0]      a,
    input  logic [17:0]      b,
    input  logic [17:0]      d,
    input  logic [47:0]      c,
    input  logic [47:0]      pcin,
    input  logic             carry_in,
    input  logic [7:0]       opmode,
    input  logic [47:0]      dut_p,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [47:0]      first_exp,
    output logic [47:0]      first_got,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_drain;
    logic [47:0]       r_gold_p;
    logic              r_pipe_v [LATENCY];
    logic [47:0]       r_pipe_p [LATENCY];
    logic              r_pipe_c [LATENCY];
    logic              r_mismatch;
    logic [CNT_W-1:0]  r_pass;
    logic [CNT_W-1:0]  r_err;
    logic [47:0]       r_first_exp;
    logic [47:0]       r_first_got;

    logic [17:0]       w_pre;
    logic [35:0]       w_m;
    logic [47:0]       w_x;
    logic [47:0]       w_z;
    logic [48:0]       w_sum;
    logic              w_accept;
    logic              w_cmp_en;
    logic              w_match;
    logic              w_fail_now;

    // Golden arithmetic: everything unsigned and wrapping at its own width.
    always_comb begin
        w_pre = b;
        if (opmode[4]) begin
            w_pre = opmode[6] ? (d - b) : (d + b);
        end
    end

    assign w_m = a * w_pre;

    always_comb begin
        case (opmode[1:0])
            2'd0:    w_x = 48'd0;
            2'd1:    w_x = {12'd0, w_m};
            2'd2:    w_x = r_gold_p;
            default: w_x = {d[11:0], a, b};
        endcase
        case (opmode[3:2])
            2'd0:    w_z = 48'd0;
            2'd1:    w_z = pcin;
            2'd2:    w_z = r_gold_p;
            default: w_z = c;
        endcase
    end

    assign w_sum = opmode[7] ? ({1'b0, w_z} - ({1'b0, w_x} + {48'd0, carry_in}))
                             : ({1'b0, w_z} + {1'b0, w_x} + {48'd0, carry_in});

    // vld_in is a one-way issue strobe with no ready: it is taken only in RUN, and the
    // matching dut_p/dut_cout must be present exactly LATENCY rising edges later.
    assign w_accept   = (r_state == S_RUN) && vld_in;
    assign w_cmp_en   = ((r_state == S_RUN) || (r_state == S_DRAIN)) && r_pipe_v[LATENCY-1];
    assign w_match    = (dut_p == r_pipe_p[LATENCY-1]) && (dut_cout == r_pipe_c[LATENCY-1]);
    assign w_fail_now = w_cmp_en && !w_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_RUN: begin
`ifdef DSP_MON_HALT_ON_ERR_EN
                    if (w_fail_now)    w_state_nxt = S_FAIL;
                    else if (stop)     w_state_nxt = S_DRAIN;
`else
                    if (stop)          w_state_nxt = S_DRAIN;
`endif
                end
                S_DRAIN: begin
`ifdef DSP_MON_HALT_ON_ERR_EN
                    if (w_fail_now)    w_state_nxt = S_FAIL;
                    else if (r_drain == 4'(LATENCY-1)) w_state_nxt = S_DONE;
`else
                    if (r_drain == 4'(LATENCY-1)) w_state_nxt = S_DONE;
`endif
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // DRAIN lasts exactly LATENCY edges so the sample issued with stop is still compared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain <= 4'd0;
        end else if (r_state != S_DRAIN) begin
            r_drain <= 4'd0;
        end else begin
            r_drain <= r_drain + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gold_p <= 48'd0;
            for (int i = 0; i < LATENCY; i++) begin
                r_pipe_v[i] <= 1'b0;
                r_pipe_p[i] <= 48'd0;
                r_pipe_c[i] <= 1'b0;
            end
        end else if (start) begin
            r_gold_p <= 48'd0;
            for (int i = 0; i < LATENCY; i++) begin
                r_pipe_v[i] <= 1'b0;
                r_pipe_p[i] <= 48'd0;
                r_pipe_c[i] <= 1'b0;
            end
        end else begin
            if (w_accept) begin
                r_gold_p <= w_sum[47:0];
            end
            r_pipe_v[0] <= w_accept;
            r_pipe_p[0] <= w_sum[47:0];
            r_pipe_c[0] <= w_sum[48];
            for (int i = 1; i < LATENCY; i++) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
                r_pipe_p[i] <= r_pipe_p[i-1];
                r_pipe_c[i] <= r_pipe_c[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mismatch  <= 1'b0;
            r_pass      <= '0;
            r_err       <= '0;
            r_first_exp <= 48'd0;
            r_first_got <= 48'd0;
        end else if (start) begin
            r_mismatch  <= 1'b0;
            r_pass      <= '0;
            r_err       <= '0;
            r_first_exp <= 48'd0;
            r_first_got <= 48'd0;
        end else begin
            r_mismatch <= 1'b0;
            if (w_cmp_en) begin
                if (w_match) begin
                    if (r_pass != '1) r_pass <= r_pass + 1'b1;
                end else begin
                    r_mismatch <= 1'b1;
                    if (r_err != '1) r_err <= r_err + 1'b1;
                    if (r_err == '0) begin
                        r_first_exp <= r_pipe_p[LATENCY-1];
                        r_first_got <= dut_p;
                    end
                end
            end
        end
    end

    assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
`ifdef DSP_MON_HALT_ON_ERR_EN
    assign done      = (r_state == S_DONE) || (r_state == S_FAIL);
`else
    assign done      = (r_state == S_DONE);
`endif
    assign mismatch  = r_mismatch;
    assign pass_cnt  = r_pass;
    assign err_cnt   = r_err;
    assign first_exp = r_first_exp;
    assign first_got = r_first_got;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_dsp48a1_result_monitor.sv
// Bench for dsp48a1_result_monitor: fake DSP responder, transaction-level model, per-cycle compare.
// Honours DSP_MON_HALT_ON_ERR_EN the same way the design does.
module tb_dsp48a1_result_monitor;

    localparam int L  = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef DSP_MON_HALT_ON_ERR_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, stop, vld_in, carry_in, dut_cout;
    logic [17:0]   a, b, d;
    logic [47:0]   c, pcin, dut_p;
    logic [7:0]    opmode;
    logic          busy, done, mismatch;
    logic [CW-1:0] pass_cnt, err_cnt;
    logic [47:0]   first_exp, first_got;
    logic [2:0]    dbg_state;

    bit corrupt;
    bit chk_en = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    dsp48a1_result_monitor #(.LATENCY(L), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .vld_in(vld_in),
        .a(a), .b(b), .d(d), .c(c), .pcin(pcin), .carry_in(carry_in), .opmode(opmode),
        .dut_p(dut_p), .dut_cout(dut_cout), .busy(busy), .done(done), .mismatch(mismatch),
        .pass_cnt(pass_cnt), .err_cnt(err_cnt), .first_exp(first_exp), .first_got(first_got),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Spec-level golden arithmetic: returns {cout, P}.
    function automatic logic [48:0] gold(input logic [7:0] op, input logic [17:0] fa, fb, fd,
                                         input logic [47:0] fc, fpc, input logic fci,
                                         input logic [47:0] gp);
        logic [17:0] pre;
        logic [47:0] m, x, z;
        pre = op[4] ? (op[6] ? fd - fb : fd + fb) : fb;
        m = 48'(fa) * 48'(pre);
        case (op[1:0])
            2'd0: x = 48'd0;
            2'd1: x = m;
            2'd2: x = gp;
            default: x = {fd[11:0], fa, fb};
        endcase
        case (op[3:2])
            2'd0: z = 48'd0;
            2'd1: z = fpc;
            2'd2: z = gp;
            default: z = fc;
        endcase
        if (op[7]) return {1'b0, z} - {1'b0, x} - 49'(fci);
        return {1'b0, z} + {1'b0, x} + 49'(fci);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Model state: mode, expected queue with due cycles, counts and first-failure capture.
    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE, M_FAIL} mmode_t;
    mmode_t       m_mode = M_IDLE;
    logic [48:0]  exp_q[$];
    int           due_q[$];
    logic [48:0]  rsp_q[$];
    int           rsp_due[$];
    int           m_pass, m_err, drain_end;
    logic         m_mis;
    logic [47:0]  m_fexp, m_fgot, m_gold;
    logic [48:0]  m_e;

    task automatic model_clear();
        m_pass = 0; m_err = 0; m_mis = 1'b0;
        m_fexp = 48'd0; m_fgot = 48'd0; m_gold = 48'd0;
        exp_q.delete(); due_q.delete(); rsp_q.delete(); rsp_due.delete();
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_clear();
            m_mode = M_IDLE;
        end else begin
            m_mis = 1'b0;
            if (start) begin
                model_clear();
                m_mode = M_RUN;
            end else begin
                if (due_q.size() > 0 && due_q[0] == cyc) begin
                    m_e = exp_q.pop_front();
                    void'(due_q.pop_front());
                    if (m_mode == M_RUN || m_mode == M_DRAIN) begin
                        if ({dut_cout, dut_p} == m_e) begin
                            if (m_pass < CMAX) m_pass++;
                        end else begin
                            m_mis = 1'b1;
                            if (m_err == 0) begin m_fexp = m_e[47:0]; m_fgot = dut_p; end
                            if (m_err < CMAX) m_err++;
                            if (HALT) m_mode = M_FAIL;
                        end
                    end
                end
                case (m_mode)
                    M_RUN: begin
                        if (vld_in) begin
                            m_e = gold(opmode, a, b, d, c, pcin, carry_in, m_gold);
                            m_gold = m_e[47:0];
                            exp_q.push_back(m_e);
                            due_q.push_back(cyc + L);
                            rsp_q.push_back(corrupt ? 49'd0 : m_e);
                            rsp_due.push_back(cyc + L);
                        end
                        if (stop) begin m_mode = M_DRAIN; drain_end = cyc + L; end
                    end
                    M_DRAIN: if (cyc == drain_end) m_mode = M_DONE;
                    default: ;
                endcase
            end
        end
    end

    // Fake DSP: presents each stored response on the edge it is due.
    always @(posedge clk) begin
        #1;
        while (rsp_due.size() > 0 && rsp_due[0] < cyc) begin
            void'(rsp_q.pop_front());
            void'(rsp_due.pop_front());
        end
        if (rsp_due.size() > 0 && rsp_due[0] == cyc) begin
            {dut_cout, dut_p} = rsp_q.pop_front();
            void'(rsp_due.pop_front());
        end else begin
            dut_cout = 1'b0;
            dut_p = 48'd0;
        end
    end

    // Scoreboard compare on every falling edge once reset has been applied.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(m_mode == M_RUN || m_mode == M_DRAIN));
            chk("done", 64'(done), 64'(m_mode == M_DONE || m_mode == M_FAIL));
            chk("mismatch", 64'(mismatch), 64'(m_mis));
            chk("pass_cnt", 64'(pass_cnt), 64'(m_pass));
            chk("err_cnt", 64'(err_cnt), 64'(m_err));
            chk("first_exp", 64'(first_exp), 64'(m_fexp));
            chk("first_got", 64'(first_got), 64'(m_fgot));
        end
    end

    // Driver tasks
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit with_stop);
        start = 1'b1; stop = with_stop;
        cycle();
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic issue(input logic [7:0] op, input logic [17:0] ia, ib, id,
                         input logic [47:0] ic, ipc, input logic ici, input bit corr, input bit stp);
        opmode = op; a = ia; b = ib; d = id; c = ic; pcin = ipc; carry_in = ici;
        corrupt = corr; stop = stp; vld_in = 1'b1;
        cycle();
        vld_in = 1'b0; stop = 1'b0; corrupt = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [17:0] a, b, d;
        logic [47:0] c, pc;
        logic        ci;
        bit          corr;
    } vec_t;
    vec_t vt[6];

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; vld_in = 1'b0; corrupt = 1'b0;
        a = '0; b = '0; d = '0; c = '0; pcin = '0; carry_in = 1'b0; opmode = '0;
        dut_p = '0; dut_cout = 1'b0;
        vt[0] = '{8'h01, 18'd300, 18'd7, 18'd0, 48'd0, 48'd0, 1'b0, 1'b0};
        vt[1] = '{8'h51, 18'd3, 18'd10, 18'd4, 48'd0, 48'd0, 1'b1, 1'b0};
        vt[2] = '{8'h05, 18'h3FFFF, 18'h3FFFF, 18'd0, 48'd0, 48'hFFFF_0000_1234, 1'b0, 1'b0};
        vt[3] = '{8'h07, 18'h2AAAA, 18'h15555, 18'hABC, 48'd0, 48'h0000_0000_0010, 1'b1, 1'b1};
        vt[4] = '{8'h8F, 18'd1, 18'd2, 18'd3, 48'hFFFF_FFFF_FFFF, 48'd0, 1'b0, 1'b0};
        vt[5] = '{8'h8A, 18'd0, 18'd0, 18'd0, 48'd0, 48'd0, 1'b1, 1'b0};
        repeat (3) cycle();
        rst_n = 1'b1;
        chk_en = 1'b1;
        cycle();

        // Hand-computed pins on the model itself.
        chk("model_t2", 64'(gold(8'h3D, 18'd9, 18'd4, 18'd1, 48'd5, 48'd0, 1'b1, 48'd0)), 64'h33);
        chk("model_t3", 64'(gold(8'h9D, 18'd2, 18'd5, 18'd15, 48'd7, 48'd0, 1'b0, 48'd0)),
            64'h1_FFFF_FFFF_FFDF);
        chk("model_t5a", 64'(gold(8'h0A, 18'd0, 18'd0, 18'd0, 48'd0, 48'd0, 1'b0, 48'h33)), 64'h66);
        chk("model_t5b", 64'(gold(8'h0A, 18'd0, 18'd0, 18'd0, 48'd0, 48'd0, 1'b0, 48'h66)), 64'hCC);

        // Issue in IDLE is ignored.
        issue(8'h3D, 18'd9, 18'd4, 18'd1, 48'd5, 48'd0, 1'b1, 1'b0, 1'b0);
        repeat (L + 1) cycle();
        chk("idle_ignore_pass", 64'(pass_cnt), 64'h0);

        // T2 + T5 with stop on the last issue (T4 timing).
        pulse_start(1'b0);
        issue(8'h3D, 18'd9, 18'd4, 18'd1, 48'd5, 48'd0, 1'b1, 1'b0, 1'b0);
        issue(8'h0A, 18'd0, 18'd0, 18'd0, 48'd0, 48'd0, 1'b0, 1'b0, 1'b0);
        issue(8'h0A, 18'd0, 18'd0, 18'd0, 48'd0, 48'd0, 1'b0, 1'b0, 1'b1);
        repeat (L - 1) cycle();
        chk("t4_done_early", 64'(done), 64'h0);
        chk("t4_busy_drain", 64'(busy), 64'h1);
        cycle();
        chk("t4_done_on_time", 64'(done), 64'h1);
        chk("t2_t5_pass", 64'(pass_cnt), 64'h3);
        repeat (2) cycle();

        // T3: single failing compare with dut_p forced to zero.
        pulse_start(1'b0);
        issue(8'h9D, 18'd2, 18'd5, 18'd15, 48'd7, 48'd0, 1'b0, 1'b1, 1'b1);
        repeat (L - 1) cycle();
        chk("t3_no_early_pulse", 64'(mismatch), 64'h0);
        cycle();
        chk("t3_mismatch", 64'(mismatch), 64'h1);
        chk("t3_err_cnt", 64'(err_cnt), 64'h1);
        chk("t3_first_exp", 64'(first_exp), 64'hFFFF_FFFF_FFDF);
        chk("t3_first_got", 64'(first_got), 64'h0);
        repeat (2) cycle();

        // Mixed vector table, one corrupted response in the middle.
        pulse_start(1'b0);
        for (int i = 0; i < 6; i++) begin
            issue(vt[i].op, vt[i].a, vt[i].b, vt[i].d, vt[i].c, vt[i].pc, vt[i].ci, vt[i].corr,
                  i == 5);
        end
        repeat (L + 2) cycle();
        chk("mixed_err", 64'(err_cnt), 64'h1);

        // Restart mid-run clears everything.
        pulse_start(1'b0);
        issue(8'h3D, 18'd9, 18'd4, 18'd1, 48'd5, 48'd0, 1'b1, 1'b1, 1'b0);
        issue(8'h3D, 18'd9, 18'd4, 18'd1, 48'd5, 48'd0, 1'b1, 1'b0, 1'b0);
        pulse_start(1'b0);
        issue(8'h3D, 18'd9, 18'd4, 18'd1, 48'd5, 48'd0, 1'b1, 1'b0, 1'b1);
        repeat (L + 2) cycle();
        chk("restart_pass", 64'(pass_cnt), 64'h1);
        chk("restart_err", 64'(err_cnt), 64'h0);

        // T6: 2^CW+3 failures saturate err_cnt (halt build stops at one).
        pulse_start(1'b0);
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            issue(8'h3D, 18'(i + 1), 18'd4, 18'd1, 48'd5, 48'd0, 1'b1, 1'b1, i == (1 << CW) + 2);
        end
        repeat (L + 2) cycle();
        chk("t6_err_sat", 64'(err_cnt), HALT ? 64'h1 : 64'(CMAX));
        chk("t6_done", 64'(done), 64'h1);

        // start and stop together: start wins.
        pulse_start(1'b1);
        chk("start_wins", 64'(busy), 64'h1);
        issue(8'h0A, 18'd0, 18'd0, 18'd0, 48'd0, 48'd0, 1'b0, 1'b0, 1'b0);

        // T1: async reset mid-run clears outputs before the next edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_busy", 64'(busy), 64'h0);
        chk("t1_pass", 64'(pass_cnt), 64'h0);
        chk("t1_done", 64'(done), 64'h0);
        chk("t1_state_idle", 64'(dbg_state), 64'h0);
        cycle();
        rst_n = 1'b1;
        repeat (L + 2) cycle();
        chk("t1_stays_idle", 64'(busy), 64'h0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
